// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled binary up/down, bouncing LED and Gray-code
// displays with run/pause, single-step and a step strobe.
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 64000000,
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             run,
    input  logic             step,
    output logic [WIDTH-1:0] led,
    output logic             tick
);

    localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [DIV_W-1:0] pre;
    logic [WIDTH-1:0] cnt;
    logic [POS_W-1:0] pos;
    dir_t             dir;
    logic             step_q;
    logic             adv;

    // While paused only a fresh rising edge of step advances the pattern.
    always_comb begin
        adv = run ? (pre == PRE_LAST) : (step & ~step_q);
    end

    assign tick = adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre    <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= step;
            if (!run || adv) begin
                pre <= '0;
            end else begin
                pre <= pre + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            pos <= '0;
            dir <= DIR_UP;
        end else if (adv) begin
            case (mode)
                2'd0, 2'd3: cnt <= cnt + WIDTH'(1);
                2'd1:       cnt <= cnt - WIDTH'(1);
                default: begin
                    // The turnaround step moves away from the end immediately.
                    if (dir == DIR_UP) begin
                        if (pos < POS_LAST) begin
                            pos <= pos + POS_W'(1);
                        end else begin
                            pos <= pos - POS_W'(1);
                            dir <= DIR_DOWN;
                        end
                    end else begin
                        if (pos != '0) begin
                            pos <= pos - POS_W'(1);
                        end else begin
                            pos <= pos + POS_W'(1);
                            dir <= DIR_UP;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        led = cnt;
        case (mode)
            2'd0, 2'd1: led = cnt;
            2'd2:       led = WIDTH'(1) << pos;
            default:    led = cnt ^ (cnt >> 1);
        endcase
    end

endmodule
